// File: rtl/alu_disp_pkg.sv
// Shared definitions for the arithmetic/7-segment display top: op codes,
// FSM states, active-high segment patterns and a digit-count helper.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB_AB = 2'b01,
    OP_SUB_BA = 2'b10,
    OP_PASS   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    CONVERT = 2'b10,
    COMMIT  = 2'b11
  } state_e;

  // Segment patterns, bit 6 = g ... bit 0 = a, 1 = segment lit.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Number of decimal digits needed to print 2^bits - 1.
  function automatic int dec_digits(input int bits);
    longint v;
    int     n;
    v = (longint'(1) << bits) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// BIN_W steps after a start pulse; done flags the final step.
module bin2bcd_seq #(
  parameter int BIN_W = 9,
  parameter int NDIG  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic [4*NDIG-1:0] bcd,
  output logic              done
);

  localparam int CNT_W = $clog2(BIN_W + 2);

  logic [BIN_W-1:0]  sh_q;
  logic [4*NDIG-1:0] bcd_q;
  logic [4*NDIG-1:0] bcd_adj;
  logic [CNT_W-1:0]  cnt_q;

  // Add 3 to every BCD digit that would overflow past 9 when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift the binary MSB into the adjusted BCD each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      cnt_q <= CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_q <= {bcd_adj[4*NDIG-2:0], sh_q[BIN_W-1]};
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/alu_bcd_display.sv
// Board-level top for the arithmetic labs: synchronises the switches,
// computes add/subtract/pass, converts to BCD and scans a signed,
// leading-zero-blanked result across a multiplexed 7-segment display.
module alu_bcd_display
  import alu_disp_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int IN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic [1:0]        op_in,
  output logic [6:0]        SSeg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  localparam int NDIG    = DIGITS - 1;
  localparam int IN_W    = 2 * WIDTH + 2;
  localparam int PRE_MAX = CLK_HZ / SCAN_HZ - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // Synchronisers reset to the switches' idle level so that "cleared"
  // means a logical zero operand and no spurious conversion after reset.
  localparam logic [IN_W-1:0] SYNC_RST = (IN_ACTIVE_LOW != 0) ? {IN_W{1'b1}} : '0;

  if (DIGITS - 1 < dec_digits(WIDTH + 1)) begin : g_digits_chk
    $error("alu_bcd_display: DIGITS-1 too small for a %0d-bit result", WIDTH + 1);
  end

  logic [IN_W-1:0]   sync_p0, sync_p1, cur, snap_q;
  logic [WIDTH-1:0]  cur_a, cur_b;
  op_e               cur_op;
  logic [WIDTH:0]    a_x, b_x, mag;
  logic              neg, sign_q;
  state_e            state_q, state_d;
  logic              conv_done;
  logic [4*NDIG-1:0] conv_bcd, disp_bcd_q;
  logic              disp_sign_q;
  logic [PRE_W-1:0]  pre_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] an_hot;
  logic [6:0]        seg_raw;
  int                msd;

  // Two-flop synchroniser on the raw switch bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= SYNC_RST;
      sync_p1 <= SYNC_RST;
    end else begin
      sync_p0 <= {a_in, b_in, op_in};
      sync_p1 <= sync_p0;
    end
  end

  assign cur    = (IN_ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;
  assign cur_a  = cur[IN_W-1 -: WIDTH];
  assign cur_b  = cur[WIDTH+1 -: WIDTH];
  assign cur_op = op_e'(cur[1:0]);
  assign a_x    = {1'b0, cur_a};
  assign b_x    = {1'b0, cur_b};

  // Sign/magnitude result; a negative sign only arises from a nonzero difference.
  always_comb begin
    mag = a_x;
    neg = 1'b0;
    case (cur_op)
      OP_ADD: mag = a_x + b_x;
      OP_SUB_AB: begin
        if (a_x >= b_x) mag = a_x - b_x;
        else begin
          mag = b_x - a_x;
          neg = 1'b1;
        end
      end
      OP_SUB_BA: begin
        if (b_x >= a_x) mag = b_x - a_x;
        else begin
          mag = a_x - b_x;
          neg = 1'b1;
        end
      end
      default: mag = a_x;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: re-compare only in IDLE, so changes during a conversion wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cur != snap_q) state_d = CAPTURE;
      CAPTURE: state_d = CONVERT;
      CONVERT: if (conv_done) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CONVERT);

  bin2bcd_seq #(
    .BIN_W(WIDTH + 1),
    .NDIG (NDIG)
  ) u_bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .start(state_q == CAPTURE),
    .bin  (mag),
    .bcd  (conv_bcd),
    .done (conv_done)
  );

  // Snapshot on capture; display registers move only on commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q      <= '0;
      sign_q      <= 1'b0;
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        snap_q <= cur;
        sign_q <= neg;
      end
      if (state_q == COMMIT) begin
        disp_bcd_q  <= conv_bcd;
        disp_sign_q <= sign_q;
      end
    end
  end

  // Scan prescaler and digit index, digit 0 rightmost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_W'(PRE_MAX)) begin
      pre_q <= '0;
      if (idx_q == IDX_W'(DIGITS - 1)) idx_q <= '0;
      else                             idx_q <= idx_q + IDX_W'(1);
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Digit pattern with leading-zero blanking and a floating minus sign.
  always_comb begin
    msd     = 0;
    seg_raw = SEG_BLANK;
    for (int i = 0; i < NDIG; i++) begin
      if (disp_bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < NDIG; i++) begin
      if (int'(idx_q) == i && (i == 0 || i <= msd)) seg_raw = seg_of(disp_bcd_q[4*i +: 4]);
    end
    if (disp_sign_q && int'(idx_q) == msd + 1) seg_raw = SEG_MINUS;
  end

  assign an_hot = DIGITS'(1) << idx_q;
  assign an     = (SEG_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
  assign SSeg   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;

endmodule

// File: tb/tb_alu_bcd_display.sv
// Directed bench for alu_bcd_display with a timing-accurate result model
// and per-cycle comparison of the scanned display.
module tb_alu_bcd_display;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int CLK_HZ  = 8;
  localparam int SCAN_HZ = 1;
  localparam int PRE = CLK_HZ / SCAN_HZ;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_in, b_in;
  logic [1:0]   op_in;
  logic [6:0]   SSeg;
  logic [D-1:0] an;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_bcd_display #(
    .WIDTH(W), .DIGITS(D), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ),
    .IN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .SSeg(SSeg), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected text of the display: decimal value, '-' if negative, right-aligned.
  function automatic string disp_str(input logic [17:0] v);
    int a, b, r;
    string s;
    a = int'(v[17:10]);
    b = int'(v[9:2]);
    case (v[1:0])
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = b - a;
      default: r = a;
    endcase
    s = $sformatf("%0d", (r < 0) ? -r : r);
    if (r < 0) s = {"-", s};
    while (s.len() < D) s = {" ", s};
    return s;
  endfunction

  // Active-low segment drive for one display character.
  function automatic logic [6:0] want_seg(input byte c);
    logic [6:0] hi;
    case (c)
      "0": hi = 7'h3F;  "1": hi = 7'h06;  "2": hi = 7'h5B;  "3": hi = 7'h4F;
      "4": hi = 7'h66;  "5": hi = 7'h6D;  "6": hi = 7'h7D;  "7": hi = 7'h07;
      "8": hi = 7'h7F;  "9": hi = 7'h6F;  "-": hi = 7'h40;
      default: hi = 7'h00;
    endcase
    return ~hi;
  endfunction

  // ---------------- model ----------------
  // Value shown changes W+4 edges after the synchronised input changes;
  // changes arriving while a job runs are picked up by the next job.
  logic [17:0] m_s1, m_s2, m_snap, m_pend, m_disp;
  int  n_edge = 0, cap_edge = -1, commit_edge = -1, busy_until = 0, scan_n = 0;
  bit  m_busy = 0, started = 0;

  initial forever begin
    logic [17:0] cur;
    @(posedge clk);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_snap = '0; m_disp = '0;
      cap_edge = -1; commit_edge = -1; busy_until = 0; scan_n = 0;
      m_busy = 0; started = 1;
    end else begin
      cur = m_s2;
      if (n_edge == cap_edge) begin
        m_snap = cur;
        m_pend = cur;
      end
      if (n_edge == commit_edge) m_disp = m_pend;
      if (n_edge >= busy_until && cur != m_snap) begin
        cap_edge    = n_edge + 1;
        commit_edge = n_edge + W + 3;
        busy_until  = n_edge + W + 4;
      end
      m_busy = (cap_edge >= 0 && n_edge >= cap_edge && n_edge <= commit_edge - 2);
      scan_n++;
      m_s2 = m_s1;
      m_s1 = {~a_in, ~b_in, ~op_in};
    end
    n_edge++;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    int idx;
    string s;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    @(negedge clk);
    if (started) begin
      idx     = (scan_n / PRE) % D;
      s       = disp_str(m_disp);
      exp_an  = ~(4'(1) << idx);
      exp_seg = want_seg(s[D-1-idx]);
      chk("an_scan", 32'(an), 32'(exp_an));
      chk("sseg_model", 32'(SSeg), 32'(exp_seg));
      chk("busy_model", 32'(busy), 32'(m_busy));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [6:0] seen [D];

  task automatic apply(input int a, input int b, input int op);
    a_in  = ~8'(a);
    b_in  = ~8'(b);
    op_in = ~2'(op);
  endtask

  task automatic read_display();
    for (int i = 0; i < D; i++) seen[i] = 7'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < D; i++) if (an == ~(4'(1) << i)) seen[i] = SSeg;
    end
  endtask

  task automatic chk_disp(input string name, input logic [6:0] d3, input logic [6:0] d2,
                          input logic [6:0] d1, input logic [6:0] d0);
    read_display();
    chk({name, "_d3"}, 32'(seen[3]), 32'(d3));
    chk({name, "_d2"}, 32'(seen[2]), 32'(d2));
    chk({name, "_d1"}, 32'(seen[1]), 32'(d1));
    chk({name, "_d0"}, 32'(seen[0]), 32'(d0));
  endtask

  task automatic wait_busy(input string name);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Active-low literals: 0=40 1=79 2=24 3=30 5=12 9=10 blank=7F minus=3F
  initial begin
    int cnt;
    rst_n = 1'b0;
    apply(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_an", 32'(an), 32'h0E);
    chk("reset_sseg", 32'(SSeg), 32'h40);
    chk("reset_busy", 32'(busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (an != 4'b1110) break;
    end
    chk("scan_step", 32'(cnt), 32'd8);
    chk_disp("reset", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    apply(200, 55, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("busy_len", 32'(cnt), 32'd9);
    chk_disp("add255", 7'h7F, 7'h24, 7'h12, 7'h12);

    apply(5, 200, 1);
    repeat (20) @(negedge clk);
    chk_disp("neg195", 7'h3F, 7'h79, 7'h10, 7'h12);
    apply(5, 200, 2);
    repeat (20) @(negedge clk);
    chk_disp("pos195", 7'h7F, 7'h79, 7'h10, 7'h12);

    apply(255, 255, 0);
    repeat (20) @(negedge clk);
    chk_disp("max510", 7'h7F, 7'h12, 7'h79, 7'h40);
    apply(77, 77, 1);
    repeat (20) @(negedge clk);
    chk_disp("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    apply(20, 0, 3);
    wait_busy("busy_rise_mid");
    a_in = ~8'd9;
    repeat (40) @(negedge clk);
    chk_disp("mid9", 7'h7F, 7'h7F, 7'h7F, 7'h10);

    apply(123, 0, 3);
    wait_busy("busy_rise_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_sseg", 32'(SSeg), 32'h40);
    chk("rst_mid_an", 32'(an), 32'h0E);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk_disp("pass123", 7'h7F, 7'h79, 7'h24, 7'h30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
